// File: rtl/branch_target_predictor_if.sv
// Fetch/execute-side signal bundle for the branch target predictor.
// The master side is the pipeline (IF lookup, EX update, decode RAS control); the slave side is the predictor.
interface branch_target_predictor_if #(
  parameter int WORD = 16
);
  logic [WORD-1:0] lookup_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [WORD-1:0] pred_target;

  logic            upd_valid;
  logic [WORD-1:0] upd_pc;
  logic            upd_taken;
  logic [WORD-1:0] upd_target;
  logic            upd_mispredict;
  logic            flush;

  logic            ras_push;
  logic [WORD-1:0] ras_push_addr;
  logic            ras_pop;
  logic [WORD-1:0] ras_top;
  logic            ras_valid;

  logic [WORD-1:0] mispredict_count;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
           flush, ras_push, ras_push_addr, ras_pop,
    input  pred_hit, pred_taken, pred_target, ras_top, ras_valid, mispredict_count
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
           flush, ras_push, ras_push_addr, ras_pop,
    output pred_hit, pred_taken, pred_target, ras_top, ras_valid, mispredict_count
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Tagged direct-mapped BTB with saturating direction counters, a circular return-address stack
// and a saturating misprediction counter. Lookup is combinational from registered state.
module branch_target_predictor #(
  parameter int WORD       = 16,
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  branch_target_predictor_if.slave  bus
);
  localparam int ENTRIES  = 2 ** INDEX_BITS;
  localparam int TAG_BITS = WORD - INDEX_BITS;
  localparam int PTR_BITS = $clog2(RAS_DEPTH);
  localparam int WT_INT   = 2 ** (CTR_BITS - 1);

  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(WT_INT);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(WT_INT - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [PTR_BITS:0]   RAS_FULL = (PTR_BITS + 1)'(RAS_DEPTH);

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [WORD-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic [WORD-1:0]     ras_q [RAS_DEPTH];
  logic [PTR_BITS-1:0] ras_ptr_q;
  logic [PTR_BITS:0]   ras_cnt_q;
  logic [WORD-1:0]     misp_q;

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;
  logic                  up_hit;

  assign lk_idx = bus.lookup_pc[INDEX_BITS-1:0];
  assign lk_tag = bus.lookup_pc[WORD-1:INDEX_BITS];
  assign up_idx = bus.upd_pc[INDEX_BITS-1:0];
  assign up_tag = bus.upd_pc[WORD-1:INDEX_BITS];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign bus.pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign bus.pred_taken  = bus.pred_hit && ctr_q[lk_idx][CTR_BITS-1];
  assign bus.pred_target = bus.pred_taken ? target_q[lk_idx] : bus.lookup_pc + WORD'(1);

  assign bus.ras_valid        = (ras_cnt_q != '0);
  assign bus.ras_top          = bus.ras_valid ? ras_q[ras_ptr_q] : '0;
  assign bus.mispredict_count = misp_q;

  // Flush only drops valid bits; counters and targets survive for re-allocation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else if (bus.flush) begin
      valid_q <= '0;
    end else if (bus.upd_valid) begin
      if (up_hit) begin
        if (bus.upd_taken) begin
          target_q[up_idx] <= bus.upd_target;
          if (ctr_q[up_idx] != CTR_MAX) ctr_q[up_idx] <= ctr_q[up_idx] + CTR_BITS'(1);
        end else if (ctr_q[up_idx] != '0) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - CTR_BITS'(1);
        end
      end else if (bus.upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bus.upd_target;
        ctr_q[up_idx]    <= CTR_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      misp_q <= '0;
    end else if (bus.upd_valid && bus.upd_mispredict && (misp_q != '1)) begin
      misp_q <= misp_q + WORD'(1);
    end
  end

  // Push+pop on a non-empty stack replaces the top in place; on an empty stack it is a plain push.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (bus.ras_push && bus.ras_pop && bus.ras_valid) begin
      ras_q[ras_ptr_q] <= bus.ras_push_addr;
    end else if (bus.ras_push) begin
      ras_q[ras_ptr_q + PTR_BITS'(1)] <= bus.ras_push_addr;
      ras_ptr_q <= ras_ptr_q + PTR_BITS'(1);
      if (ras_cnt_q != RAS_FULL) ras_cnt_q <= ras_cnt_q + (PTR_BITS + 1)'(1);
    end else if (bus.ras_pop && bus.ras_valid) begin
      ras_ptr_q <= ras_ptr_q - PTR_BITS'(1);
      ras_cnt_q <= ras_cnt_q - (PTR_BITS + 1)'(1);
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed-vector bench for branch_target_predictor; a narrow 4-bit build checks counter saturation.
module tb_branch_target_predictor;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  branch_target_predictor_if #(.WORD(16)) bif ();
  branch_target_predictor_if #(.WORD(4))  sif ();

  branch_target_predictor #(.WORD(16), .INDEX_BITS(4), .CTR_BITS(2), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bif.slave)
  );

  branch_target_predictor #(.WORD(4), .INDEX_BITS(2), .CTR_BITS(2), .RAS_DEPTH(4)) dut_small (
    .clk(clk), .reset_n(reset_n), .bus(sif.slave)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bif.upd_valid = 0; bif.upd_pc = '0; bif.upd_taken = 0; bif.upd_target = '0;
    bif.upd_mispredict = 0; bif.flush = 0; bif.ras_push = 0; bif.ras_push_addr = '0;
    bif.ras_pop = 0;
    sif.lookup_pc = '0; sif.upd_valid = 0; sif.upd_pc = '0; sif.upd_taken = 0;
    sif.upd_target = '0; sif.upd_mispredict = 0; sif.flush = 0; sif.ras_push = 0;
    sif.ras_push_addr = '0; sif.ras_pop = 0;
  endtask

  task automatic upd(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
    bif.upd_valid = 1; bif.upd_pc = pc; bif.upd_taken = taken; bif.upd_target = tgt;
    cyc();
    bif.upd_valid = 0; bif.upd_taken = 0;
  endtask

  task automatic ras_op(input logic push, input logic pop, input logic [15:0] addr);
    bif.ras_push = push; bif.ras_pop = pop; bif.ras_push_addr = addr;
    cyc();
    bif.ras_push = 0; bif.ras_pop = 0;
  endtask

  task automatic test_reset();
    idle_all();
    bif.lookup_pc = 16'h0003;
    reset_n = 0;
    cyc(); cyc();
    reset_n = 1;
    #1;
    n_vec++; if (bif.pred_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit got=%b exp=0", bif.pred_hit); end
    n_vec++; if (bif.pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken got=%b exp=0", bif.pred_taken); end
    n_vec++; if (bif.pred_target !== 16'h0004) begin n_err++; $display("FAIL reset_target got=%h exp=0004", bif.pred_target); end
    n_vec++; if (bif.ras_valid !== 1'b0) begin n_err++; $display("FAIL reset_ras_valid got=%b exp=0", bif.ras_valid); end
    n_vec++; if (bif.ras_top !== 16'h0000) begin n_err++; $display("FAIL reset_ras_top got=%h exp=0000", bif.ras_top); end
    n_vec++; if (bif.mispredict_count !== 16'h0000) begin n_err++; $display("FAIL reset_misp got=%h exp=0000", bif.mispredict_count); end
  endtask

  task automatic test_alloc();
    bif.lookup_pc = 16'h0013;
    bif.upd_valid = 1; bif.upd_pc = 16'h0013; bif.upd_taken = 1; bif.upd_target = 16'h0040;
    #1;
    n_vec++; if (bif.pred_hit !== 1'b0) begin n_err++; $display("FAIL same_cycle_hit got=%b exp=0", bif.pred_hit); end
    cyc();
    bif.upd_valid = 0; bif.upd_taken = 0;
    n_vec++; if (bif.pred_hit !== 1'b1) begin n_err++; $display("FAIL alloc_hit got=%b exp=1", bif.pred_hit); end
    n_vec++; if (bif.pred_taken !== 1'b1) begin n_err++; $display("FAIL alloc_taken got=%b exp=1", bif.pred_taken); end
    n_vec++; if (bif.pred_target !== 16'h0040) begin n_err++; $display("FAIL alloc_target got=%h exp=0040", bif.pred_target); end
    bif.lookup_pc = 16'h0023; #1;
    n_vec++; if (bif.pred_hit !== 1'b0) begin n_err++; $display("FAIL tag_mismatch_hit got=%b exp=0", bif.pred_hit); end
    n_vec++; if (bif.pred_target !== 16'h0024) begin n_err++; $display("FAIL tag_mismatch_target got=%h exp=0024", bif.pred_target); end
    upd(16'h0005, 1'b0, 16'h0070);
    bif.lookup_pc = 16'h0005; #1;
    n_vec++; if (bif.pred_hit !== 1'b0) begin n_err++; $display("FAIL miss_not_taken_alloc got=%b exp=0", bif.pred_hit); end
  endtask

  task automatic test_counter();
    bif.lookup_pc = 16'h0013;
    upd(16'h0013, 1'b0, 16'h0077);
    n_vec++; if (bif.pred_taken !== 1'b0) begin n_err++; $display("FAIL ctr1_taken got=%b exp=0", bif.pred_taken); end
    n_vec++; if (bif.pred_target !== 16'h0014) begin n_err++; $display("FAIL ctr1_target got=%h exp=0014", bif.pred_target); end
    upd(16'h0013, 1'b0, 16'h0077);
    upd(16'h0013, 1'b0, 16'h0077);
    n_vec++; if (bif.pred_hit !== 1'b1) begin n_err++; $display("FAIL ctr0_hit got=%b exp=1", bif.pred_hit); end
    n_vec++; if (bif.pred_taken !== 1'b0) begin n_err++; $display("FAIL ctr0_sat_taken got=%b exp=0", bif.pred_taken); end
    upd(16'h0013, 1'b1, 16'h0055);
    n_vec++; if (bif.pred_taken !== 1'b0) begin n_err++; $display("FAIL ctr_up1_taken got=%b exp=0", bif.pred_taken); end
    upd(16'h0013, 1'b1, 16'h0055);
    n_vec++; if (bif.pred_taken !== 1'b1) begin n_err++; $display("FAIL ctr_up2_taken got=%b exp=1", bif.pred_taken); end
    upd(16'h0013, 1'b1, 16'h0055);
    upd(16'h0013, 1'b1, 16'h0055);
    upd(16'h0013, 1'b1, 16'h0055);
    upd(16'h0013, 1'b0, 16'h0077);
    n_vec++; if (bif.pred_taken !== 1'b1) begin n_err++; $display("FAIL ctr3_sat_nt_taken got=%b exp=1", bif.pred_taken); end
    n_vec++; if (bif.pred_target !== 16'h0055) begin n_err++; $display("FAIL nt_keeps_target got=%h exp=0055", bif.pred_target); end
    upd(16'h0013, 1'b0, 16'h0077);
    n_vec++; if (bif.pred_taken !== 1'b0) begin n_err++; $display("FAIL ctr_down_to1_taken got=%b exp=0", bif.pred_taken); end
  endtask

  task automatic test_flush();
    upd(16'h0013, 1'b1, 16'h0040);
    bif.flush = 1;
    upd(16'h0007, 1'b1, 16'h0090);
    bif.flush = 0;
    bif.lookup_pc = 16'h0013; #1;
    n_vec++; if (bif.pred_hit !== 1'b0) begin n_err++; $display("FAIL flush_old_hit got=%b exp=0", bif.pred_hit); end
    bif.lookup_pc = 16'h0007; #1;
    n_vec++; if (bif.pred_hit !== 1'b0) begin n_err++; $display("FAIL flush_new_hit got=%b exp=0", bif.pred_hit); end
    n_vec++; if (bif.pred_target !== 16'h0008) begin n_err++; $display("FAIL flush_new_target got=%h exp=0008", bif.pred_target); end
  endtask

  task automatic test_ras();
    logic [15:0] exp_top [4];
    exp_top[0] = 16'd5; exp_top[1] = 16'd4; exp_top[2] = 16'd3; exp_top[3] = 16'd2;
    for (int i = 1; i <= 5; i++) ras_op(1'b1, 1'b0, 16'(i));
    n_vec++; if (bif.ras_valid !== 1'b1) begin n_err++; $display("FAIL ras_full_valid got=%b exp=1", bif.ras_valid); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bif.ras_top !== exp_top[i]) begin n_err++; $display("FAIL ras_pop%0d_top got=%h exp=%h", i, bif.ras_top, exp_top[i]); end
      ras_op(1'b0, 1'b1, 16'h0000);
    end
    n_vec++; if (bif.ras_valid !== 1'b0) begin n_err++; $display("FAIL ras_drained_valid got=%b exp=0", bif.ras_valid); end
    ras_op(1'b0, 1'b1, 16'h0000);
    n_vec++; if (bif.ras_valid !== 1'b0 || bif.ras_top !== 16'h0000) begin
      n_err++; $display("FAIL ras_pop_empty got=%b/%h exp=0/0000", bif.ras_valid, bif.ras_top); end
    ras_op(1'b1, 1'b0, 16'h0007);
    ras_op(1'b1, 1'b1, 16'h0009);
    n_vec++; if (bif.ras_top !== 16'h0009) begin n_err++; $display("FAIL ras_pushpop_top got=%h exp=0009", bif.ras_top); end
    ras_op(1'b0, 1'b1, 16'h0000);
    n_vec++; if (bif.ras_valid !== 1'b0) begin n_err++; $display("FAIL ras_pushpop_depth got=%b exp=0", bif.ras_valid); end
    ras_op(1'b1, 1'b1, 16'h0021);
    n_vec++; if (bif.ras_valid !== 1'b1 || bif.ras_top !== 16'h0021) begin
      n_err++; $display("FAIL ras_pushpop_empty got=%b/%h exp=1/0021", bif.ras_valid, bif.ras_top); end
  endtask

  task automatic test_mispredict();
    bif.upd_mispredict = 1;
    for (int i = 0; i < 3; i++) upd(16'h0031, 1'b0, 16'h0000);
    cyc();
    bif.upd_mispredict = 0;
    n_vec++; if (bif.mispredict_count !== 16'd3) begin n_err++; $display("FAIL misp_count got=%0d exp=3", bif.mispredict_count); end
    sif.upd_valid = 1; sif.upd_mispredict = 1; sif.upd_pc = 4'h1;
    for (int i = 0; i < 14; i++) cyc();
    n_vec++; if (sif.mispredict_count !== 4'hE) begin n_err++; $display("FAIL misp_small_14 got=%h exp=e", sif.mispredict_count); end
    cyc();
    n_vec++; if (sif.mispredict_count !== 4'hF) begin n_err++; $display("FAIL misp_small_15 got=%h exp=f", sif.mispredict_count); end
    for (int i = 0; i < 5; i++) cyc();
    n_vec++; if (sif.mispredict_count !== 4'hF) begin n_err++; $display("FAIL misp_small_hold got=%h exp=f", sif.mispredict_count); end
    sif.upd_valid = 0; sif.upd_mispredict = 0;
  endtask

  task automatic test_reset_mid();
    upd(16'h0013, 1'b1, 16'h0040);
    ras_op(1'b1, 1'b0, 16'h0033);
    reset_n = 0;
    bif.upd_valid = 1; bif.upd_pc = 16'h002A; bif.upd_taken = 1; bif.upd_target = 16'h0011;
    bif.upd_mispredict = 1; bif.ras_push = 1; bif.ras_push_addr = 16'h0044;
    cyc();
    reset_n = 1;
    idle_all();
    bif.lookup_pc = 16'h0013; #1;
    n_vec++; if (bif.pred_hit !== 1'b0) begin n_err++; $display("FAIL rstmid_old_hit got=%b exp=0", bif.pred_hit); end
    bif.lookup_pc = 16'h002A; #1;
    n_vec++; if (bif.pred_hit !== 1'b0) begin n_err++; $display("FAIL rstmid_upd_hit got=%b exp=0", bif.pred_hit); end
    n_vec++; if (bif.ras_valid !== 1'b0 || bif.ras_top !== 16'h0000) begin
      n_err++; $display("FAIL rstmid_ras got=%b/%h exp=0/0000", bif.ras_valid, bif.ras_top); end
    n_vec++; if (bif.mispredict_count !== 16'h0000) begin n_err++; $display("FAIL rstmid_misp got=%h exp=0000", bif.mispredict_count); end
    n_vec++; if (sif.mispredict_count !== 4'h0) begin n_err++; $display("FAIL rstmid_small_misp got=%h exp=0", sif.mispredict_count); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_flush();
    test_ras();
    test_mispredict();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
